// File: rtl/mipi_lane_tx.sv
// Single-lane MIPI D-PHY HS transmit sequencer: LP request/prepare, HS-zero, sync,
// payload, trail and LP-11 exit, feeding an 8:1 serializer in the byte-clock domain.
module mipi_lane_tx #(
  parameter int unsigned T_LPX   = 2,
  parameter int unsigned T_PREP  = 2,
  parameter int unsigned T_ZERO  = 4,
  parameter int unsigned T_TRAIL = 2,
  parameter int unsigned T_EXIT  = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] hs_data,
  output logic       hs_oe,
  output logic       lp_p,
  output logic       lp_n,
  output logic       busy,
  output logic       underflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LPRQ,
    S_PREP,
    S_ZERO,
    S_SYNC,
    S_DATA,
    S_TRAIL,
    S_EXIT
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  // Counter reload values; a zero duration behaves as a single cycle.
  localparam logic [CNT_W-1:0] LPX_LD   = CNT_W'((T_LPX   == 0) ? 0 : T_LPX   - 1);
  localparam logic [CNT_W-1:0] PREP_LD  = CNT_W'((T_PREP  == 0) ? 0 : T_PREP  - 1);
  localparam logic [CNT_W-1:0] ZERO_LD  = CNT_W'((T_ZERO  == 0) ? 0 : T_ZERO  - 1);
  localparam logic [CNT_W-1:0] TRAIL_LD = CNT_W'((T_TRAIL == 0) ? 0 : T_TRAIL - 1);
  localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'((T_EXIT  == 0) ? 0 : T_EXIT  - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             cnt_done;
  logic             last_b7, last_b7_nxt;
  logic [7:0]       hs_data_nxt;
  logic             hs_oe_nxt;
  logic             lp_p_nxt;
  logic             lp_n_nxt;
  logic             busy_nxt;
  logic             underflow_nxt;

  assign cnt_done = (cnt == '0);
  assign tx_ready = (state == S_DATA);

  // Output registers capture the line condition of the state being held this cycle,
  // so an accepted payload byte reaches hs_data one edge after its handshake.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    last_b7_nxt   = last_b7;
    hs_data_nxt   = '0;
    hs_oe_nxt     = 1'b0;
    lp_p_nxt      = 1'b1;
    lp_n_nxt      = 1'b1;
    busy_nxt      = (state != S_IDLE);
    underflow_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (tx_valid) begin
          state_nxt = S_LPRQ;
          cnt_nxt   = LPX_LD;
        end
      end
      S_LPRQ: begin
        lp_p_nxt = 1'b0;
        if (cnt_done) begin
          state_nxt = S_PREP;
          cnt_nxt   = PREP_LD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_PREP: begin
        lp_p_nxt = 1'b0;
        lp_n_nxt = 1'b0;
        if (cnt_done) begin
          state_nxt = S_ZERO;
          cnt_nxt   = ZERO_LD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_ZERO: begin
        lp_p_nxt  = 1'b0;
        lp_n_nxt  = 1'b0;
        hs_oe_nxt = 1'b1;
        if (cnt_done) begin
          state_nxt = S_SYNC;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_SYNC: begin
        lp_p_nxt    = 1'b0;
        lp_n_nxt    = 1'b0;
        hs_oe_nxt   = 1'b1;
        hs_data_nxt = SYNC_BYTE;
        last_b7_nxt = SYNC_BYTE[7];
        state_nxt   = S_DATA;
      end
      S_DATA: begin
        lp_p_nxt  = 1'b0;
        lp_n_nxt  = 1'b0;
        hs_oe_nxt = 1'b1;
        if (tx_valid) begin
          hs_data_nxt = tx_data;
          last_b7_nxt = tx_data[7];
          if (tx_last) begin
            state_nxt = S_TRAIL;
            cnt_nxt   = TRAIL_LD;
          end
        end else begin
          // Underrun: fill the empty slot with trail polarity so no stale byte repeats.
          hs_data_nxt   = {8{~last_b7}};
          underflow_nxt = 1'b1;
          state_nxt     = S_TRAIL;
          cnt_nxt       = TRAIL_LD;
        end
      end
      S_TRAIL: begin
        lp_p_nxt    = 1'b0;
        lp_n_nxt    = 1'b0;
        hs_oe_nxt   = 1'b1;
        hs_data_nxt = {8{~last_b7}};
        if (cnt_done) begin
          state_nxt = S_EXIT;
          cnt_nxt   = EXIT_LD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_EXIT: begin
        if (cnt_done) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state     <= S_IDLE;
      cnt       <= '0;
      last_b7   <= 1'b0;
      hs_data   <= '0;
      hs_oe     <= 1'b0;
      lp_p      <= 1'b1;
      lp_n      <= 1'b1;
      busy      <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      last_b7   <= last_b7_nxt;
      hs_data   <= hs_data_nxt;
      hs_oe     <= hs_oe_nxt;
      lp_p      <= lp_p_nxt;
      lp_n      <= lp_n_nxt;
      busy      <= busy_nxt;
      underflow <= underflow_nxt;
    end
  end

endmodule

// File: doc/mipi_lane_tx.md
Name: mipi_lane_tx

Overview:
- Single-lane MIPI D-PHY high-speed transmit sequencer. It is the transmit counterpart of the lane deserializer.
- Takes a byte stream with a valid/ready/last handshake and generates the full burst: LP-11 → LP-01 → LP-00 → HS-zero → sync byte → payload → HS-trail → LP-11.
- Drives an 8:1 output serializer (hs_data/hs_oe) and the LP line drivers. Sits in the byte-clock domain: clk is the serializer's divided clock.

Parameters:
T_LPX, 2, cycles in LP-01 (request state)
T_PREP, 2, cycles in LP-00 (HS-prepare)
T_ZERO, 4, cycles of HS-zero bytes (8'h00) before sync
T_TRAIL, 2, cycles of trail bytes after the last payload byte
T_EXIT, 4, minimum cycles in LP-11 before another burst may start
CNT_W, 8, width of the shared timing counter; all T_* must be ≤ 2^CNT_W-1

Ports:
clk  in  1  byte clock (serializer divided clock)
resetb  in  1  asynchronous active-low reset
tx_valid  in  1  payload byte available
tx_data  in  8  payload byte, protocol order (bit 0 transmitted first)
tx_last  in  1  tx_data is the final byte of the burst
tx_ready  out  1  block accepts tx_data this cycle
hs_data  out  8  byte to serializer, bit 0 first on the wire
hs_oe  out  1  HS driver enable
lp_p  out  1  LP driver, P line
lp_n  out  1  LP driver, N line
busy  out  1  high in every state except IDLE
underflow  out  1  one-cycle pulse on payload underrun

Behaviour:
- Reset (async, resetb=0):
  - State → IDLE, counter → 0.
  - hs_data=8'h00, hs_oe=0, lp_p=1, lp_n=1, busy=0, underflow=0.
  - These values apply immediately, including mid-burst.
- All outputs except tx_ready are registered. tx_ready is combinational: (state==DATA).
- Each timed state loads the counter with T_x-1 on entry and exits when the counter is 0. A T_x of 0 is treated as 1.
- State machine:
  - IDLE: lp=11, hs_oe=0. If tx_valid=1 → LPRQ. No byte is consumed.
  - LPRQ: lp_p=0, lp_n=1 for T_LPX cycles → PREP.
  - PREP: lp=00, hs_oe=0 for T_PREP cycles → ZERO.
  - ZERO: lp=00, hs_oe=1, hs_data=8'h00 for T_ZERO cycles → SYNC.
  - SYNC: hs_data=8'hB8 for exactly 1 cycle → DATA.
  - DATA: tx_ready=1.
    - On tx_valid=1, the byte is accepted and appears on hs_data at the next edge (latency 1).
    - If the accepted byte has tx_last=1 → TRAIL.
    - If tx_valid=0 in DATA (underrun): pulse underflow for 1 cycle, accept no byte, → TRAIL. Trail is based on the last byte actually sent; if no payload byte was sent, it is based on the sync byte.
  - TRAIL: hs_data={8{~b7}} for T_TRAIL cycles, where b7 is bit 7 of the last byte sent (the final wire bit) → EXIT.
  - EXIT: hs_oe=0, hs_data=8'h00, lp=11 for T_EXIT cycles → IDLE. tx_valid is ignored until IDLE is reached.
- LP transitions and hs_oe change on the same clock edge as the state register. lp=00 is held throughout ZERO, SYNC, DATA and TRAIL.
- Back-to-back bursts: tx_valid held high through EXIT starts the next LPRQ on the first IDLE cycle. There is always at least one IDLE cycle between bursts.
- A single-byte burst (first byte has tx_last=1) is legal: SYNC, one DATA byte, then TRAIL.
- tx_last is ignored when tx_valid=0.
- Byte count per burst is unbounded. No internal buffering; the source must sustain 1 byte/cycle in DATA.

Test Plan:
- Reset values: assert resetb=0 mid-DATA → same cycle hs_oe=0, lp_p=lp_n=1, busy=0. Release, then tx_valid=0 → the block stays IDLE.
- Nominal 4-byte burst (01,02,03,84; last on 84) with defaults:
  - lp sequence 11, then 01×2, then 00×2.
  - hs_oe=1 with hs_data 00×4, B8, 01, 02, 03, 84, then 00×2 (trail, since b7 of 84 is 1, ~b7=0).
  - hs_oe=0 with lp=11 ×4, then IDLE.
  - tx_ready high for 4 cycles.
- Trail polarity: last byte 8'h7F → trail bytes 8'hFF×T_TRAIL.
- Underrun: drop tx_valid after 2 bytes (AA, 55) → underflow pulses once, then trail bytes FF×2 (b7 of 55 is 0), then normal EXIT.
- Single-byte burst with T_ZERO=1 and T_LPX=0 (treated as 1): byte 0x1D with last → LPRQ 1 cycle, ZERO 1 cycle, B8, 1D, then trail FF×2.
- Back-to-back: tx_valid held high across two 2-byte bursts → exactly 1 IDLE cycle after T_EXIT before the second LPRQ; no byte is consumed outside DATA.
